// File: rtl/icache_refill.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : icache_refill                                               |
// | Brief    : Wishbone incrementing-burst line refill engine for icache.  |
// |            Optional macro ICACHE_REFILL_RETRY_EN: rty re-issues beat.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module icache_refill #(
  parameter int LINE_BEATS  = 8,
  parameter int OFFSET_BITS = 5,
  parameter int BEAT_CNT_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_req,
  input  logic [31:0]              miss_paddr,
  input  logic                     abort,
  output logic                     refill_busy,
  output logic                     refill_we,
  output logic [LINE_BEATS*32-1:0] line_data,
  output logic                     refill_err,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [31:0]              wb_adr_o,
  output logic [3:0]               wb_sel_o,
  output logic [2:0]               wb_cti_o,
  output logic [1:0]               wb_bte_o,
  output logic [31:0]              wb_dat_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic [31:0]              wb_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BURST = 3'd1,
    S_WRITE = 3'd2,
    S_ERR   = 3'd3,
    S_RGAP  = 3'd4
  } state_t;

  localparam logic [BEAT_CNT_W-1:0] c_last_beat = BEAT_CNT_W'(LINE_BEATS - 1);
  localparam logic [2:0]            c_cti_incr  = 3'b010;
  localparam logic [2:0]            c_cti_end   = 3'b111;
  localparam logic [2:0]            c_cti_first = (LINE_BEATS == 1) ? c_cti_end : c_cti_incr;
`ifdef ICACHE_REFILL_RETRY_EN
  localparam state_t                c_rty_next  = S_RGAP;
`else
  localparam state_t                c_rty_next  = S_ERR;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [BEAT_CNT_W-1:0] r_beat;
  logic [BEAT_CNT_W-1:0] w_beat_inc;
  logic                  w_ack;
  logic                  w_err;
  logic                  w_rty;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_store;
  logic [31:0]           w_base;
  logic                  w_unused;

  // Offset bits of the miss address never reach the bus.
  assign w_unused   = ^miss_paddr[OFFSET_BITS-1:0];
  assign w_base     = {miss_paddr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  assign w_ack      = wb_ack_i & wb_cyc_o & wb_stb_o;
  assign w_err      = wb_err_i & wb_cyc_o & wb_stb_o;
  assign w_rty      = wb_rty_i & wb_cyc_o & wb_stb_o;
  assign w_last     = (r_beat == c_last_beat);
  assign w_beat_inc = r_beat + BEAT_CNT_W'(1);
  assign w_accept   = (r_state == S_IDLE) & miss_req & ~abort;
  // A beat is captured even when abort arrives with it; err/rty outrank ack.
  assign w_store    = (r_state == S_BURST) & w_ack & ~w_err & ~w_rty;

  assign wb_we_o    = 1'b0;
  assign wb_bte_o   = 2'b00;
  assign wb_dat_o   = 32'h0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_BURST;
      end
      S_BURST: begin
        if (abort)                w_next = S_IDLE;
        else if (w_err)           w_next = S_ERR;
        else if (w_rty)           w_next = c_rty_next;
        else if (w_ack && w_last) w_next = S_WRITE;
      end
      S_WRITE: w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      S_RGAP:  w_next = abort ? S_IDLE : S_BURST;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      refill_busy <= 1'b0;
      refill_we   <= 1'b0;
      refill_err  <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_adr_o    <= 32'h0;
      wb_sel_o    <= 4'h0;
      wb_cti_o    <= 3'b000;
      line_data   <= '0;
    end else begin
      r_state     <= w_next;
      // Outputs are decoded from the next state so they line up with it.
      refill_busy <= (w_next != S_IDLE);
      refill_we   <= (w_next == S_WRITE);
      refill_err  <= (w_next == S_ERR);
      wb_cyc_o    <= (w_next == S_BURST) || (w_next == S_RGAP);
      wb_stb_o    <= (w_next == S_BURST);
      wb_sel_o    <= 4'hF;

      if (w_accept) begin
        r_beat   <= '0;
        wb_adr_o <= w_base;
        wb_cti_o <= c_cti_first;
      end else if (w_store && !w_last) begin
        r_beat   <= w_beat_inc;
        wb_adr_o <= wb_adr_o + 32'd4;
        wb_cti_o <= (w_beat_inc == c_last_beat) ? c_cti_end : c_cti_incr;
      end

      if (w_store) begin
        line_data[32*r_beat +: 32] <= wb_dat_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_icache_refill                                            |
// | Brief    : Directed + random checks of icache_refill vs a line model.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_icache_refill;

  logic         clk = 1'b0;
  logic         rst_n, miss_req, abort, wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0]  miss_paddr, wb_dat_i;
  logic         refill_busy, refill_we, refill_err, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [255:0] line_data;
  logic [31:0]  wb_adr_o, wb_dat_o;
  logic [3:0]   wb_sel_o;
  logic [2:0]   wb_cti_o;
  logic [1:0]   wb_bte_o;

  int total = 0;
  int bad   = 0;

  // Reference: an open refill owns the bus, has received m_k beats of line m_base.
  bit          m_act, m_gap, m_we, m_err;
  int          m_k;
  logic [31:0] m_base;
  logic [31:0] m_line [8];

  always #5 clk = ~clk;

  icache_refill dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_paddr(miss_paddr),
    .abort(abort), .refill_busy(refill_busy), .refill_we(refill_we),
    .line_data(line_data), .refill_err(refill_err), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = m_line[i];
    return v;
  endfunction

  task automatic check_outputs();
    chk("busy", refill_busy, m_act | m_we | m_err);
    chk("cyc",  wb_cyc_o,    m_act);
    chk("stb",  wb_stb_o,    m_act & ~m_gap);
    chk("we",   refill_we,   m_we);
    chk("err",  refill_err,  m_err);
    chk("line", line_data,   model_line());
    chk("wbwe", {wb_we_o, wb_bte_o, wb_dat_o}, '0);
    if (m_act && !m_gap) begin
      chk("adr", wb_adr_o, m_base + 32'(4 * m_k));
      chk("cti", wb_cti_o, (m_k == 7) ? 3'b111 : 3'b010);
      chk("sel", wb_sel_o, 4'hF);
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input bit rn, input bit rq, input logic [31:0] pa, input bit ab,
                      input bit ak, input bit er, input bit ry, input logic [31:0] d);
    bit nwe, nerr;
    nwe = 1'b0;
    nerr = 1'b0;
    rst_n = rn; miss_req = rq; miss_paddr = pa; abort = ab;
    wb_ack_i = ak; wb_err_i = er; wb_rty_i = ry; wb_dat_i = d;
    if (!rn) begin
      m_act = 1'b0; m_gap = 1'b0; m_k = 0;
      for (int i = 0; i < 8; i++) m_line[i] = 32'h0;
    end else if (m_act && m_gap) begin
      m_gap = 1'b0;
      if (ab) m_act = 1'b0;
    end else if (m_act) begin
      if (ak && !er && !ry) m_line[m_k] = d;
      if (ab) m_act = 1'b0;
      else if (er) begin m_act = 1'b0; nerr = 1'b1; end
      else if (ry) begin
`ifdef ICACHE_REFILL_RETRY_EN
        m_gap = 1'b1;
`else
        m_act = 1'b0; nerr = 1'b1;
`endif
      end else if (ak) begin
        if (m_k == 7) begin m_act = 1'b0; nwe = 1'b1; end
        else m_k++;
      end
    end else if (!m_we && !m_err && rq && !ab) begin
      m_act = 1'b1; m_k = 0; m_base = {pa[31:5], 5'b0};
    end
    m_we = nwe;
    m_err = nerr;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic beat(input bit ak, input bit er, input bit ry, input bit ab, input logic [31:0] d);
    step(1'b1, 1'b0, 32'h0, ab, ak, er, ry, d);
  endtask

  task automatic request(input logic [31:0] pa);
    step(1'b1, 1'b1, pa, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    bit rn, rq, ab, ak, er, ry;
    int n;
    rst_n = 1'b0; miss_req = 1'b0; miss_paddr = 32'h0; abort = 1'b0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = 32'h0;

    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_line", line_data, '0);

    // 1: zero-wait burst, data = beat index
    request(32'h0000_1234);
    for (int b = 0; b < 8; b++) begin
      chk("t1_adr", wb_adr_o, 32'h0000_1220 + 32'(4 * b));
      chk("t1_cti", wb_cti_o, (b == 7) ? 3'b111 : 3'b010);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 32'(b));
    end
    chk("t1_we", refill_we, 1'b1);
    chk("t1_cyc", wb_cyc_o, 1'b0);
    chk("t1_lo", line_data[31:0], 32'h0);
    chk("t1_hi", line_data[255:224], 32'h7);
    idle();
    chk("t1_busy", refill_busy, 1'b0);

    // 2: ack on alternate cycles
    request(32'h0000_1234);
    n = 0;
    for (int c = 0; c < 16; c++) begin
      if (wb_stb_o) n++;
      beat(c[0], 1'b0, 1'b0, 1'b0, 32'hB000_0000 + 32'(c));
    end
    chk("t2_cycles", n, 16);
    chk("t2_we", refill_we, 1'b1);
    idle();

    // 3: err on beat 3
    request(32'h0000_4000);
    for (int b = 0; b < 3; b++) beat(1'b1, 1'b0, 1'b0, 1'b0, 32'hA0 + 32'(b));
    beat(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("t3_err", refill_err, 1'b1);
    chk("t3_cyc", wb_cyc_o, 1'b0);
    chk("t3_b2", line_data[95:64], 32'hA2);
    idle();
    chk("t3_busy", refill_busy, 1'b0);

    // 4: abort after 4 acks, then a fresh request restarts at beat 0
    request(32'h0000_8040);
    for (int b = 0; b < 4; b++) beat(1'b1, 1'b0, 1'b0, 1'b0, 32'hC0 + 32'(b));
    beat(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("t4_cyc", wb_cyc_o, 1'b0);
    chk("t4_busy", refill_busy, 1'b0);
    idle();
    request(32'h0000_9000);
    chk("t4_adr0", wb_adr_o, 32'h0000_9000);
    for (int b = 0; b < 8; b++) beat(1'b1, 1'b0, 1'b0, 1'b0, 32'hD0 + 32'(b));
    chk("t4_we", refill_we, 1'b1);
    idle();

    // 5: reset at beat 5, then a complete refill
    request(32'h0001_0000);
    for (int b = 0; b < 5; b++) beat(1'b1, 1'b0, 1'b0, 1'b0, 32'hE0 + 32'(b));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t5_outs", {refill_busy, refill_we, refill_err, wb_cyc_o, wb_stb_o, wb_adr_o, wb_cti_o}, '0);
    chk("t5_line", line_data, '0);
    request(32'h0001_0000);
    for (int b = 0; b < 8; b++) beat(1'b1, 1'b0, 1'b0, 1'b0, 32'hF0 + 32'(b));
    chk("t5_we", refill_we, 1'b1);
    idle();

    // 6: rty on beat 2
    request(32'h0000_1234);
    for (int b = 0; b < 2; b++) beat(1'b1, 1'b0, 1'b0, 1'b0, 32'h10 + 32'(b));
    beat(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
`ifdef ICACHE_REFILL_RETRY_EN
    chk("t6_gap", {wb_cyc_o, wb_stb_o}, 2'b10);
    idle();
    chk("t6_adr", wb_adr_o, 32'h0000_1228);
    for (int b = 2; b < 8; b++) beat(1'b1, 1'b0, 1'b0, 1'b0, 32'h10 + 32'(b));
    chk("t6_we", refill_we, 1'b1);
`else
    chk("t6_err", refill_err, 1'b1);
    chk("t6_we", refill_we, 1'b0);
`endif
    idle();

    // Random traffic, including stray acks outside stb and abort/ack overlap
    for (int c = 0; c < 3000; c++) begin
      rn = ($urandom_range(199) != 0);
      rq = ($urandom_range(1) != 0);
      ab = ($urandom_range(29) == 0);
      ak = wb_stb_o ? ($urandom_range(9) < 6) : ($urandom_range(9) == 0);
      er = wb_stb_o && ($urandom_range(39) == 0);
      ry = wb_stb_o && ($urandom_range(24) == 0);
      step(rn, rq, $urandom, ab, ak, er, ry, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
